// File: rtl/upd_mux_pkg.sv
// Shared defaults and helpers for the round-robin update mux.
package upd_mux_pkg;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      int unsigned x;
      r = 0;
      x = (value > 0) ? value - 1 : 0;
      while (x > 0) begin
         r++;
         x = x >> 1;
      end
      return r;
   endfunction

   localparam int unsigned DEF_WIDTH      = 8;
   localparam int unsigned DEF_NUM_INPUTS = 16;
   localparam int unsigned DEF_WIDTH_SEL  = clog2(DEF_NUM_INPUTS);
   localparam int unsigned CNT_W          = 16;

endpackage

// File: rtl/upd_rr_mux_arbiter.sv
// Combinational round-robin search: first requesting lane at or above ptr, wrapping.
module rr_arbiter
   import upd_mux_pkg::*;
#(
   parameter int unsigned NUM_INPUTS = DEF_NUM_INPUTS,
   parameter int unsigned WIDTH_sel  = DEF_WIDTH_SEL
) (
   input  logic [NUM_INPUTS-1:0] req,
   input  logic [WIDTH_sel-1:0]  ptr,
   output logic [NUM_INPUTS-1:0] gnt,
   output logic [WIDTH_sel-1:0]  gnt_idx,
   output logic                  any_req
);

   int unsigned idx;
   logic        found;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = 0;
      for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
         // ptr is always < NUM_INPUTS, so a single subtraction wraps the index
         idx = 32'(ptr) + i;
         if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
         if (!found && req[idx]) begin
            found        = 1'b1;
            gnt[idx]     = 1'b1;
            gnt_idx      = idx[WIDTH_sel-1:0];
         end
      end
   end

   assign any_req = |req;

endmodule

// File: rtl/upd_rr_mux.sv
// Round-robin N:1 update mux with registered output stage.
// Optional transfer counter output cnt_o enabled by macro UPD_RR_MUX_CNT_EN.
module upd_rr_mux
   import upd_mux_pkg::*;
#(
   parameter int unsigned WIDTH      = DEF_WIDTH,
   parameter int unsigned WIDTH_sel  = DEF_WIDTH_SEL,
   parameter int unsigned NUM_INPUTS = DEF_NUM_INPUTS
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_INPUTS*WIDTH-1:0] a_i,
   input  logic [NUM_INPUTS-1:0]       valid_i,
   output logic [NUM_INPUTS-1:0]       ready_o,
   output logic [WIDTH-1:0]            y_o,
   output logic [WIDTH_sel-1:0]        sel_o,
   output logic                        valid_o,
   input  logic                        ready_i
`ifdef UPD_RR_MUX_CNT_EN
   ,
   output logic [CNT_W-1:0]            cnt_o
`endif
);

   logic [NUM_INPUTS-1:0] gnt;
   logic [WIDTH_sel-1:0]  gnt_idx;
   logic [WIDTH_sel-1:0]  ptr;
   logic [WIDTH_sel-1:0]  ptr_next;
   logic                  any_req;
   logic                  load;
   logic                  accept;
   logic [WIDTH-1:0]      win_word;

   rr_arbiter #(
      .NUM_INPUTS (NUM_INPUTS),
      .WIDTH_sel  (WIDTH_sel)
   ) u_arb (
      .req     (valid_i),
      .ptr     (ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any_req (any_req)
   );

   assign load     = !valid_o || ready_i;
   // rst_n gates the grant so ready_o is forced low while reset is held
   assign accept   = rst_n && load && any_req;
   assign ready_o  = accept ? gnt : '0;
   assign win_word = a_i[gnt_idx*WIDTH +: WIDTH];
   assign ptr_next = (gnt_idx == WIDTH_sel'(NUM_INPUTS - 1)) ? '0 : gnt_idx + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr     <= '0;
         y_o     <= '0;
         sel_o   <= '0;
         valid_o <= 1'b0;
      end else if (load) begin
         if (any_req) begin
            y_o     <= win_word;
            sel_o   <= gnt_idx;
            valid_o <= 1'b1;
            ptr     <= ptr_next;
         end else begin
            valid_o <= 1'b0;
         end
      end
   end

`ifdef UPD_RR_MUX_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_o <= '0;
      else if (valid_o && ready_i && cnt_o != '1)
         cnt_o <= cnt_o + 1'b1;
   end
`endif

endmodule
